// File: rtl/trap_entry_sequencer_pkg.sv
// Shared types and constants for the machine-mode trap entry / mret sequencer.
// Imported by the sequencer and its interface.
package trap_entry_sequencer_pkg;

    localparam int unsigned XLEN           = 32;
    localparam int unsigned CAUSE_W        = 4;
    localparam int unsigned MCAUSE_INT_BIT = XLEN - 1;

    // Machine-level interrupt cause codes
    localparam logic [CAUSE_W-1:0] CAUSE_MSI = 4'd3;
    localparam logic [CAUSE_W-1:0] CAUSE_MTI = 4'd7;
    localparam logic [CAUSE_W-1:0] CAUSE_MEI = 4'd11;

    typedef enum logic [2:0] {
        StIdle,
        StDrain,
        StEnter,
        StReturn,
        StCool
    } trap_state_e;

endpackage

// File: rtl/trap_entry_sequencer_if.sv
// Signals between interrupt/pipeline sources and the trap entry sequencer.
// The slave modport is the sequencer; master is the surrounding core logic.
interface trap_entry_sequencer_if #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned CAUSE_W = 4
) ();

    logic               irq_pending;
    logic [CAUSE_W-1:0] irq_cause;
    logic               mret_exe;
    logic               exe_valid;
    logic [XLEN-1:0]    exe_pc;
    logic               mem_busy;
    logic               stall_pipl;

    logic               interrupt;
    logic               mret_type;
    logic               trap_busy;
    logic               redirect_valid;
    logic               redirect_sel;
    logic               csr_trap_we;
    logic               csr_mret_we;
    logic [XLEN-1:0]    csr_mepc;
    logic [XLEN-1:0]    csr_mcause;
    logic               drain_timeout;

    modport master (
        output irq_pending, irq_cause, mret_exe, exe_valid, exe_pc, mem_busy, stall_pipl,
        input  interrupt, mret_type, trap_busy, redirect_valid, redirect_sel,
        input  csr_trap_we, csr_mret_we, csr_mepc, csr_mcause, drain_timeout
    );

    modport slave (
        input  irq_pending, irq_cause, mret_exe, exe_valid, exe_pc, mem_busy, stall_pipl,
        output interrupt, mret_type, trap_busy, redirect_valid, redirect_sel,
        output csr_trap_we, csr_mret_we, csr_mepc, csr_mcause, drain_timeout
    );

endinterface

// File: rtl/trap_entry_sequencer.sv
// Machine-mode interrupt entry and mret return sequencer: drains MEM, then pulses the
// pipeline flush, PC redirect and CSR write strobes. All outputs are registered.
module trap_entry_sequencer
    import trap_entry_sequencer_pkg::*;
#(
    parameter int unsigned XLEN      = trap_entry_sequencer_pkg::XLEN,
    parameter int unsigned CAUSE_W   = trap_entry_sequencer_pkg::CAUSE_W,
    parameter int unsigned DRAIN_MAX = 15
) (
    input  logic                  clk,
    input  logic                  reset_n,
    trap_entry_sequencer_if.slave bus
);

    localparam int unsigned CntW = $clog2(DRAIN_MAX + 1);

    trap_state_e     state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            latch_csr;
    logic            timeout_d;
    logic [XLEN-1:0] mcause_d;

    logic            interrupt_q, mret_type_q, trap_busy_q, redirect_valid_q, redirect_sel_q;
    logic            csr_trap_we_q, csr_mret_we_q, drain_timeout_q;
    logic [XLEN-1:0] csr_mepc_q, csr_mcause_q;

    always_comb begin
        mcause_d                = '0;
        mcause_d[CAUSE_W-1:0]   = bus.irq_cause;
        mcause_d[XLEN-1]        = 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        latch_csr = 1'b0;
        timeout_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                // mret wins over a simultaneous interrupt
                if (bus.mret_exe && !bus.stall_pipl) begin
                    state_d = StReturn;
                end else if (bus.irq_pending && bus.exe_valid) begin
                    state_d   = StDrain;
                    latch_csr = 1'b1;
                end
            end
            StDrain: begin
                if (!bus.irq_pending) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (!bus.mem_busy && !bus.stall_pipl) begin
                    state_d = StEnter;
                    cnt_d   = '0;
                end else if (cnt_q == CntW'(DRAIN_MAX)) begin
                    state_d   = StEnter;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StEnter:  state_d = StCool;
            StReturn: state_d = StCool;
            StCool:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they are Moore in state_q.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= StIdle;
            cnt_q            <= '0;
            csr_mepc_q       <= '0;
            csr_mcause_q     <= '0;
            interrupt_q      <= 1'b0;
            mret_type_q      <= 1'b0;
            trap_busy_q      <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_sel_q   <= 1'b0;
            csr_trap_we_q    <= 1'b0;
            csr_mret_we_q    <= 1'b0;
            drain_timeout_q  <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            if (latch_csr) begin
                csr_mepc_q   <= bus.exe_pc;
                csr_mcause_q <= mcause_d;
            end
            interrupt_q      <= (state_d == StEnter);
            mret_type_q      <= (state_d == StReturn);
            trap_busy_q      <= (state_d != StIdle);
            redirect_valid_q <= (state_d == StEnter) || (state_d == StReturn);
            redirect_sel_q   <= (state_d == StReturn);
            csr_trap_we_q    <= (state_d == StEnter);
            csr_mret_we_q    <= (state_d == StReturn);
            drain_timeout_q  <= timeout_d;
        end
    end

    assign bus.interrupt      = interrupt_q;
    assign bus.mret_type      = mret_type_q;
    assign bus.trap_busy      = trap_busy_q;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_sel   = redirect_sel_q;
    assign bus.csr_trap_we    = csr_trap_we_q;
    assign bus.csr_mret_we    = csr_mret_we_q;
    assign bus.csr_mepc       = csr_mepc_q;
    assign bus.csr_mcause     = csr_mcause_q;
    assign bus.drain_timeout  = drain_timeout_q;

endmodule

// File: tb/tb_trap_entry_sequencer.sv
// Directed self-checking bench for trap_entry_sequencer.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_trap_entry_sequencer;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_errors;
    logic seen;

    trap_entry_sequencer_if #(.XLEN(32), .CAUSE_W(4)) bus ();

    trap_entry_sequencer #(
        .XLEN     (32),
        .CAUSE_W  (4),
        .DRAIN_MAX(15)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_intr"}, 32'(bus.interrupt), 32'd0);
        check_eq({tag, "_mret"}, 32'(bus.mret_type), 32'd0);
        check_eq({tag, "_busy"}, 32'(bus.trap_busy), 32'd0);
        check_eq({tag, "_rv"}, 32'(bus.redirect_valid), 32'd0);
        check_eq({tag, "_twe"}, 32'(bus.csr_trap_we), 32'd0);
        check_eq({tag, "_mwe"}, 32'(bus.csr_mret_we), 32'd0);
        check_eq({tag, "_tmo"}, 32'(bus.drain_timeout), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset_n = 1'b0;
        bus.irq_pending = 1'b0;
        bus.irq_cause   = '0;
        bus.mret_exe    = 1'b0;
        bus.exe_valid   = 1'b0;
        bus.exe_pc      = '0;
        bus.mem_busy    = 1'b0;
        bus.stall_pipl  = 1'b0;
        #23;
        check_idle_outputs("rst");
        check_eq("rst_mepc", bus.csr_mepc, 32'h0);
        check_eq("rst_mcause", bus.csr_mcause, 32'h0);
        reset_n = 1'b1;
        step();

        // Idle MEM: one DRAIN cycle, then ENTER
        bus.irq_pending = 1'b1;
        bus.irq_cause   = 4'd7;
        bus.exe_pc      = 32'h100;
        bus.exe_valid   = 1'b1;
        step();
        check_eq("t1_drain_busy", 32'(bus.trap_busy), 32'd1);
        check_eq("t1_drain_intr", 32'(bus.interrupt), 32'd0);
        check_eq("t1_mepc", bus.csr_mepc, 32'h100);
        check_eq("t1_mcause", bus.csr_mcause, 32'h8000_0007);
        step();
        check_eq("t1_intr", 32'(bus.interrupt), 32'd1);
        check_eq("t1_twe", 32'(bus.csr_trap_we), 32'd1);
        check_eq("t1_rv", 32'(bus.redirect_valid), 32'd1);
        check_eq("t1_sel", 32'(bus.redirect_sel), 32'd0);
        check_eq("t1_tmo", 32'(bus.drain_timeout), 32'd0);
        bus.irq_pending = 1'b0;
        bus.exe_valid   = 1'b0;
        step();
        check_eq("t1_cool_intr", 32'(bus.interrupt), 32'd0);
        check_eq("t1_cool_busy", 32'(bus.trap_busy), 32'd1);
        step();
        check_idle_outputs("t1_idle");

        // MEM busy for 5 cycles
        bus.irq_pending = 1'b1;
        bus.irq_cause   = 4'd11;
        bus.exe_pc      = 32'h200;
        bus.exe_valid   = 1'b1;
        bus.mem_busy    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("t2_busy", 32'(bus.trap_busy), 32'd1);
            check_eq("t2_nointr", 32'(bus.interrupt), 32'd0);
        end
        bus.mem_busy = 1'b0;
        step();
        check_eq("t2_intr", 32'(bus.interrupt), 32'd1);
        check_eq("t2_tmo", 32'(bus.drain_timeout), 32'd0);
        check_eq("t2_mepc", bus.csr_mepc, 32'h200);
        check_eq("t2_mcause", bus.csr_mcause, 32'h8000_000B);
        bus.irq_pending = 1'b0;
        bus.exe_valid   = 1'b0;
        step();
        step();
        check_idle_outputs("t2_idle");

        // MEM stuck busy: forced entry after DRAIN_MAX+1 DRAIN cycles
        bus.irq_pending = 1'b1;
        bus.irq_cause   = 4'd3;
        bus.exe_pc      = 32'h300;
        bus.exe_valid   = 1'b1;
        bus.mem_busy    = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            check_eq("t3_nointr", 32'(bus.interrupt), 32'd0);
            check_eq("t3_notmo", 32'(bus.drain_timeout), 32'd0);
        end
        step();
        check_eq("t3_intr", 32'(bus.interrupt), 32'd1);
        check_eq("t3_tmo", 32'(bus.drain_timeout), 32'd1);
        check_eq("t3_mcause", bus.csr_mcause, 32'h8000_0003);
        bus.irq_pending = 1'b0;
        bus.exe_valid   = 1'b0;
        bus.mem_busy    = 1'b0;
        step();
        check_eq("t3_cool_tmo", 32'(bus.drain_timeout), 32'd0);
        step();
        check_idle_outputs("t3_idle");

        // irq withdrawn on the 3rd DRAIN cycle: abandon
        seen = 1'b0;
        bus.irq_pending = 1'b1;
        bus.irq_cause   = 4'd7;
        bus.exe_pc      = 32'h400;
        bus.exe_valid   = 1'b1;
        bus.mem_busy    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            seen = seen | bus.interrupt | bus.csr_trap_we | bus.redirect_valid;
        end
        check_eq("t4_drain_busy", 32'(bus.trap_busy), 32'd1);
        bus.irq_pending = 1'b0;
        bus.exe_valid   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            seen = seen | bus.interrupt | bus.csr_trap_we | bus.redirect_valid;
        end
        bus.mem_busy = 1'b0;
        check_eq("t4_idle_busy", 32'(bus.trap_busy), 32'd0);
        check_eq("t4_no_pulse", 32'(seen), 32'd0);
        check_eq("t4_mepc", bus.csr_mepc, 32'h400);

        // mret held off by stall, then mret beats a simultaneous irq
        bus.mret_exe   = 1'b1;
        bus.stall_pipl = 1'b1;
        step();
        check_eq("t5_stall_busy", 32'(bus.trap_busy), 32'd0);
        bus.stall_pipl  = 1'b0;
        bus.irq_pending = 1'b1;
        bus.exe_valid   = 1'b1;
        bus.irq_cause   = 4'd7;
        bus.exe_pc      = 32'h500;
        step();
        check_eq("t5_mret", 32'(bus.mret_type), 32'd1);
        check_eq("t5_sel", 32'(bus.redirect_sel), 32'd1);
        check_eq("t5_rv", 32'(bus.redirect_valid), 32'd1);
        check_eq("t5_mwe", 32'(bus.csr_mret_we), 32'd1);
        check_eq("t5_intr", 32'(bus.interrupt), 32'd0);
        check_eq("t5_twe", 32'(bus.csr_trap_we), 32'd0);
        bus.mret_exe = 1'b0;
        step();
        check_eq("t5_cool_mret", 32'(bus.mret_type), 32'd0);
        check_eq("t5_cool_busy", 32'(bus.trap_busy), 32'd1);
        step();
        check_eq("t5_idle_busy", 32'(bus.trap_busy), 32'd0);
        step();
        check_eq("t5_drain_busy", 32'(bus.trap_busy), 32'd1);
        check_eq("t5_mepc", bus.csr_mepc, 32'h500);
        step();
        check_eq("t5_intr2", 32'(bus.interrupt), 32'd1);
        bus.irq_pending = 1'b0;
        bus.exe_valid   = 1'b0;
        step();
        step();

        // Async reset while in DRAIN
        bus.irq_pending = 1'b1;
        bus.exe_valid   = 1'b1;
        bus.exe_pc      = 32'h600;
        bus.mem_busy    = 1'b1;
        step();
        step();
        check_eq("t6_pre_busy", 32'(bus.trap_busy), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_idle_outputs("t6_rst");
        check_eq("t6_rst_mepc", bus.csr_mepc, 32'h0);
        check_eq("t6_rst_mcause", bus.csr_mcause, 32'h0);
        bus.irq_pending = 1'b0;
        bus.exe_valid   = 1'b0;
        bus.mem_busy    = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_idle_outputs("t6_post");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
